// File: rtl/fast_pkg.sv
// Shared definitions for the dispatch front end: opcodes, register index width,
// FSM states and the instruction decoder.
package fast_pkg;

    localparam int unsigned REG_IDX_W = 6;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;

    typedef enum logic {StRun, StRecover} state_e;

    typedef struct packed {
        logic [REG_IDX_W-1:0] src1;
        logic [REG_IDX_W-1:0] src2;
        logic [REG_IDX_W-1:0] dest;
        logic                 is_branch;
        logic                 is_load;
        logic                 writer;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t                 d;
        logic [5:0]           op;
        logic [REG_IDX_W-1:0] rs;
        logic [REG_IDX_W-1:0] rt;
        logic [REG_IDX_W-1:0] rd;
        op          = instr[31:26];
        rs          = {1'b0, instr[25:21]};
        rt          = {1'b0, instr[20:16]};
        rd          = {1'b0, instr[15:11]};
        d.src1      = rs;
        d.src2      = rs;
        d.dest      = rt;
        d.is_branch = 1'b0;
        d.is_load   = (op == OP_LW);
        case (op)
            OP_RTYPE: begin
                d.src2 = rt;
                d.dest = rd;
            end
            OP_BEQ, OP_BNE: begin
                d.src2      = rt;
                d.dest      = '0;
                d.is_branch = 1'b1;
            end
            default: ;
        endcase
        // Loads never get a writeback from the core, so they must not mark pending.
        d.writer = ((op == OP_RTYPE) || (op == OP_ADDI)) && (d.dest != '0);
        return d;
    endfunction

endpackage

// File: rtl/fast_dispatch_if.sv
// Fetch, core-issue and core-feedback signals of the dispatch block.
// master = dispatch block, slave = fetch unit plus fast_core.
interface fast_dispatch_if;

    logic [31:0]                    fetch_instr;
    logic                           fetch_pred_taken;
    logic                           fetch_valid;
    logic                           fetch_ready;
    logic [31:0]                    instr_in;
    logic                           instr_valid;
    logic [fast_pkg::REG_IDX_W-1:0] src1_index;
    logic [fast_pkg::REG_IDX_W-1:0] src2_index;
    logic [fast_pkg::REG_IDX_W-1:0] dest_index;
    logic                           src1_valid;
    logic                           src2_valid;
    logic                           is_branch;
    logic                           is_load;
    logic                           result_valid;
    logic [fast_pkg::REG_IDX_W-1:0] result_index;
    logic                           branch_resolved;
    logic                           branch_taken;
    logic                           recovery_trigger;
    logic [15:0]                    mispredict_count;

    modport master (
        input  fetch_instr, fetch_pred_taken, fetch_valid, result_valid, result_index,
               branch_resolved, branch_taken,
        output fetch_ready, instr_in, instr_valid, src1_index, src2_index, dest_index,
               src1_valid, src2_valid, is_branch, is_load, recovery_trigger, mispredict_count
    );

    modport slave (
        output fetch_instr, fetch_pred_taken, fetch_valid, result_valid, result_index,
               branch_resolved, branch_taken,
        input  fetch_ready, instr_in, instr_valid, src1_index, src2_index, dest_index,
               src1_valid, src2_valid, is_branch, is_load, recovery_trigger, mispredict_count
    );

endinterface

// File: rtl/fast_sync_fifo.sv
// Synchronous FIFO with occupancy count and synchronous flush; push when full
// and pop when empty are ignored.
module fast_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push_ok = push_i && (count_q != CntW'(Depth));
    assign pop_ok  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = push_ok ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CntW'(push_ok) - CntW'(pop_ok);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fast_dispatch.sv
// In-order dispatch front end for fast_core: instruction queue, scoreboard
// interlock, branch prediction tracking and mispredict recovery.
module fast_dispatch
    import fast_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned MAX_BR = 4
) (
    input logic            clk,
    input logic            rst_n,
    fast_dispatch_if.master bus
);

    localparam int unsigned QCntW = $clog2(DEPTH + 1);
    localparam int unsigned BCntW = $clog2(MAX_BR + 1);
    localparam int unsigned NRegs = 1 << REG_IDX_W;

    state_e             state_q, state_d;
    logic               init_q;
    logic               recover, fetch_ready;
    logic [QCntW-1:0]   q_count;
    logic [32:0]        q_rdata;
    logic               q_full, q_empty, q_push;
    logic [BCntW-1:0]   br_count;
    logic               br_rdata, br_full, br_empty, br_push, br_pop, mispredict;
    dec_t               head;
    logic               src1_rdy, src2_rdy, dispatch;
    logic [NRegs-1:0]   pending_q, pending_d;
    logic [31:0]        instr_q;
    logic [REG_IDX_W-1:0] src1_q, src2_q, dest_q;
    logic               is_branch_q, is_load_q, instr_valid_q, src_valid_q;
    logic [15:0]        mcount_q;

    assign q_full   = (q_count == QCntW'(DEPTH));
    assign q_empty  = (q_count == '0);
    assign br_full  = (br_count == BCntW'(MAX_BR));
    assign br_empty = (br_count == '0);
    assign q_push   = bus.fetch_valid && fetch_ready;
    assign head     = decode(q_rdata[31:0]);

    // A writeback in the same cycle counts as ready.
    assign src1_rdy = !pending_q[head.src1] ||
                      (bus.result_valid && (bus.result_index == head.src1));
    assign src2_rdy = !pending_q[head.src2] ||
                      (bus.result_valid && (bus.result_index == head.src2));
    assign dispatch = (state_q == StRun) && !q_empty && src1_rdy && src2_rdy &&
                      (!head.is_branch || !br_full);

    assign br_push    = dispatch && head.is_branch;
    assign br_pop     = (state_q == StRun) && bus.branch_resolved && !br_empty;
    assign mispredict = br_pop && (br_rdata != bus.branch_taken);

    fast_sync_fifo #(.Width(33), .Depth(DEPTH)) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (recover),
        .push_i  (q_push),
        .wdata_i ({bus.fetch_pred_taken, bus.fetch_instr}),
        .pop_i   (dispatch),
        .rdata_o (q_rdata),
        .count_o (q_count)
    );

    fast_sync_fifo #(.Width(1), .Depth(MAX_BR)) u_tracker (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (recover),
        .push_i  (br_push),
        .wdata_i (q_rdata[32]),
        .pop_i   (br_pop),
        .rdata_o (br_rdata),
        .count_o (br_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:     if (mispredict) state_d = StRecover;
            StRecover: state_d = StRun;
        endcase
    end

    // init_q keeps fetch_ready low until the first edge after reset release.
    always_comb begin
        recover     = (state_q == StRecover);
        fetch_ready = init_q && (state_q == StRun) && !q_full;
    end

    // A set from dispatch overrides a clear from a same-cycle writeback.
    always_comb begin
        pending_d = pending_q;
        if (bus.result_valid) pending_d[bus.result_index] = 1'b0;
        if (dispatch && head.writer) pending_d[head.dest] = 1'b1;
        if (recover) pending_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q     <= '0;
            instr_q       <= '0;
            src1_q        <= '0;
            src2_q        <= '0;
            dest_q        <= '0;
            is_branch_q   <= 1'b0;
            is_load_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            src_valid_q   <= 1'b0;
            mcount_q      <= '0;
        end else begin
            pending_q     <= pending_d;
            instr_valid_q <= dispatch;
            src_valid_q   <= dispatch;
            if (dispatch) begin
                instr_q     <= q_rdata[31:0];
                src1_q      <= head.src1;
                src2_q      <= head.src2;
                dest_q      <= head.dest;
                is_branch_q <= head.is_branch;
                is_load_q   <= head.is_load;
            end
            if (recover && (mcount_q != 16'hFFFF)) mcount_q <= mcount_q + 16'd1;
        end
    end

    assign bus.fetch_ready      = fetch_ready;
    assign bus.instr_in         = instr_q;
    assign bus.instr_valid      = instr_valid_q;
    assign bus.src1_index       = src1_q;
    assign bus.src2_index       = src2_q;
    assign bus.dest_index       = dest_q;
    assign bus.src1_valid       = src_valid_q;
    assign bus.src2_valid       = src_valid_q;
    assign bus.is_branch        = is_branch_q;
    assign bus.is_load          = is_load_q;
    assign bus.recovery_trigger = recover;
    assign bus.mispredict_count = mcount_q;

endmodule

// File: tb/tb_fast_dispatch.sv
// Directed self-checking bench for fast_dispatch.
module tb_fast_dispatch;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    logic [31:0] disp_q [$];
    int   recov_cnt = 0;

    always #5 clk = ~clk;

    fast_dispatch_if bus ();

    fast_dispatch #(.DEPTH(8), .MAX_BR(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] filler(input int i);
        return 32'h2000_0000 | (32'(12 + i) << 16) | 32'(i);
    endfunction

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.instr_valid === 1'b1) disp_q.push_back(bus.instr_in);
        if (bus.recovery_trigger === 1'b1) recov_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.fetch_instr = '0; bus.fetch_pred_taken = 1'b0; bus.fetch_valid = 1'b0;
        bus.result_valid = 1'b0; bus.result_index = '0;
        bus.branch_resolved = 1'b0; bus.branch_taken = 1'b0;
        #3;
        tests++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL rst_instr_valid: got %b want 0", bus.instr_valid); end
        tests++; if (bus.fetch_ready !== 1'b0) begin fails++; $display("FAIL rst_fetch_ready: got %b want 0", bus.fetch_ready); end
        tests++; if (bus.recovery_trigger !== 1'b0) begin fails++; $display("FAIL rst_recovery: got %b want 0", bus.recovery_trigger); end
        tests++; if (bus.mispredict_count !== 16'd0) begin fails++; $display("FAIL rst_mcount: got %0d want 0", bus.mispredict_count); end
        tests++; if (bus.instr_in !== 32'd0) begin fails++; $display("FAIL rst_instr_in: got %h want 0", bus.instr_in); end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        tests++; if (bus.fetch_ready !== 1'b0) begin fails++; $display("FAIL rel_fetch_ready_pre: got %b want 0", bus.fetch_ready); end
        tick();
        tests++; if (bus.fetch_ready !== 1'b1) begin fails++; $display("FAIL rel_fetch_ready: got %b want 1", bus.fetch_ready); end
    endtask

    task automatic test_independent();
        bus.fetch_instr = 32'h0022_1820; bus.fetch_valid = 1'b1;
        tick();
        bus.fetch_instr = 32'h20A4_0001;
        tick();
        tests++; if (bus.instr_valid !== 1'b1) begin fails++; $display("FAIL ind_v0: got %b want 1", bus.instr_valid); end
        tests++; if ({bus.src1_index, bus.src2_index, bus.dest_index} !== {6'd1, 6'd2, 6'd3}) begin
            fails++; $display("FAIL ind_idx0: got %0d,%0d,%0d want 1,2,3", bus.src1_index, bus.src2_index, bus.dest_index); end
        tests++; if (bus.src1_valid !== 1'b1 || bus.src2_valid !== 1'b1) begin
            fails++; $display("FAIL ind_srcv0: got %b%b want 11", bus.src1_valid, bus.src2_valid); end
        tests++; if (bus.instr_in !== 32'h0022_1820) begin fails++; $display("FAIL ind_instr0: got %h want 00221820", bus.instr_in); end
        bus.fetch_valid = 1'b0;
        tick();
        tests++; if (bus.instr_valid !== 1'b1) begin fails++; $display("FAIL ind_v1: got %b want 1", bus.instr_valid); end
        tests++; if ({bus.src1_index, bus.src2_index, bus.dest_index} !== {6'd5, 6'd5, 6'd4}) begin
            fails++; $display("FAIL ind_idx1: got %0d,%0d,%0d want 5,5,4", bus.src1_index, bus.src2_index, bus.dest_index); end
        tick();
        tests++; if (bus.instr_valid !== 1'b0 || bus.src1_valid !== 1'b0) begin
            fails++; $display("FAIL ind_idle: got v=%b s=%b want 0,0", bus.instr_valid, bus.src1_valid); end
        tests++; if (bus.dest_index !== 6'd4) begin fails++; $display("FAIL ind_hold: got %0d want 4", bus.dest_index); end
    endtask

    task automatic test_raw_stall();
        int n0;
        bus.fetch_instr = 32'h0063_3020; bus.fetch_valid = 1'b1;
        tick();
        bus.fetch_valid = 1'b0;
        n0 = disp_q.size();
        repeat (3) tick();
        tests++; if (disp_q.size() != n0) begin fails++; $display("FAIL raw3_stall: got %0d dispatches want 0", disp_q.size() - n0); end
        bus.result_valid = 1'b1; bus.result_index = 6'd3;
        tick();
        bus.result_valid = 1'b0;
        tests++; if (bus.instr_valid !== 1'b1 || bus.dest_index !== 6'd6) begin
            fails++; $display("FAIL raw3_bypass: got v=%b dest=%0d want 1,6", bus.instr_valid, bus.dest_index); end
        bus.fetch_instr = 32'h0080_3820; bus.fetch_valid = 1'b1;
        tick();
        bus.fetch_valid = 1'b0;
        n0 = disp_q.size();
        repeat (2) tick();
        tests++; if (disp_q.size() != n0) begin fails++; $display("FAIL raw4_stall: got %0d dispatches want 0", disp_q.size() - n0); end
        bus.result_valid = 1'b1; bus.result_index = 6'd4;
        tick();
        bus.result_valid = 1'b0;
        tests++; if (bus.instr_valid !== 1'b1 || bus.dest_index !== 6'd7) begin
            fails++; $display("FAIL raw4_bypass: got v=%b dest=%0d want 1,7", bus.instr_valid, bus.dest_index); end
    endtask

    task automatic test_load();
        bus.fetch_instr = 32'h8C29_0000; bus.fetch_valid = 1'b1;
        tick();
        bus.fetch_instr = 32'h0120_5020;
        tick();
        bus.fetch_valid = 1'b0;
        tests++; if (bus.instr_valid !== 1'b1 || bus.is_load !== 1'b1) begin
            fails++; $display("FAIL lw_flags: got v=%b ld=%b want 1,1", bus.instr_valid, bus.is_load); end
        tests++; if ({bus.src1_index, bus.src2_index, bus.dest_index} !== {6'd1, 6'd1, 6'd9}) begin
            fails++; $display("FAIL lw_idx: got %0d,%0d,%0d want 1,1,9", bus.src1_index, bus.src2_index, bus.dest_index); end
        tick();
        tests++; if (bus.instr_valid !== 1'b1 || bus.src1_index !== 6'd9 || bus.is_load !== 1'b0) begin
            fails++; $display("FAIL lw_nopend: got v=%b s1=%0d ld=%b want 1,9,0", bus.instr_valid, bus.src1_index, bus.is_load); end
    endtask

    task automatic test_full();
        int accepts;
        int base;
        accepts = 0;
        bus.fetch_instr = 32'h00C6_5820; bus.fetch_valid = 1'b1;
        tick();
        accepts++;
        for (int i = 0; i < 8; i++) begin
            bus.fetch_instr = filler(i);
            if (bus.fetch_ready !== 1'b1) break;
            tick();
            accepts++;
        end
        tests++; if (accepts != 8) begin fails++; $display("FAIL full_accepts: got %0d want 8", accepts); end
        tests++; if (bus.fetch_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b want 0", bus.fetch_ready); end
        tick();
        tests++; if (bus.fetch_ready !== 1'b0) begin fails++; $display("FAIL full_hold: got %b want 0", bus.fetch_ready); end
        base = disp_q.size();
        bus.result_valid = 1'b1; bus.result_index = 6'd6;
        tick();
        bus.result_valid = 1'b0;
        tests++; if (bus.instr_valid !== 1'b1 || bus.dest_index !== 6'd11) begin
            fails++; $display("FAIL full_head: got v=%b dest=%0d want 1,11", bus.instr_valid, bus.dest_index); end
        tests++; if (bus.fetch_ready !== 1'b1) begin fails++; $display("FAIL full_reopen: got %b want 1", bus.fetch_ready); end
        tick();
        bus.fetch_valid = 1'b0;
        repeat (10) tick();
        tests++; if (disp_q.size() - base != 9) begin fails++; $display("FAIL full_drain: got %0d want 9", disp_q.size() - base); end
        for (int i = 0; i < 8; i++) begin
            if (base + 1 + i < disp_q.size()) begin
                tests++; if (disp_q[base + 1 + i] !== filler(i)) begin
                    fails++; $display("FAIL full_order%0d: got %h want %h", i, disp_q[base + 1 + i], filler(i)); end
            end
        end
    endtask

    task automatic test_branch_ok();
        int n0;
        bus.fetch_instr = 32'h1022_0000; bus.fetch_pred_taken = 1'b1; bus.fetch_valid = 1'b1;
        tick();
        bus.fetch_valid = 1'b0;
        tick();
        tests++; if (bus.instr_valid !== 1'b1 || bus.is_branch !== 1'b1 || bus.dest_index !== 6'd0) begin
            fails++; $display("FAIL br_disp: got v=%b br=%b dest=%0d want 1,1,0", bus.instr_valid, bus.is_branch, bus.dest_index); end
        bus.branch_resolved = 1'b1; bus.branch_taken = 1'b1;
        tick();
        bus.branch_resolved = 1'b0;
        tick();
        tests++; if (recov_cnt != 0) begin fails++; $display("FAIL br_norecov: got %0d want 0", recov_cnt); end
        // Tracker must be empty again: four branches fit, the fifth waits.
        bus.fetch_pred_taken = 1'b0; bus.fetch_valid = 1'b1;
        n0 = disp_q.size();
        repeat (5) tick();
        bus.fetch_valid = 1'b0;
        repeat (3) tick();
        tests++; if (disp_q.size() - n0 != 4) begin fails++; $display("FAIL br_trk_full: got %0d want 4", disp_q.size() - n0); end
        bus.branch_resolved = 1'b1; bus.branch_taken = 1'b0;
        tick();
        bus.branch_resolved = 1'b0;
        tick();
        tests++; if (disp_q.size() - n0 != 5) begin fails++; $display("FAIL br_trk_free: got %0d want 5", disp_q.size() - n0); end
        bus.branch_resolved = 1'b1;
        repeat (4) tick();
        bus.branch_resolved = 1'b0;
        tick();
        tests++; if (recov_cnt != 0 || bus.mispredict_count !== 16'd0) begin
            fails++; $display("FAIL br_clean: got recov=%0d cnt=%0d want 0,0", recov_cnt, bus.mispredict_count); end
    endtask

    task automatic test_mispredict();
        int n0;
        n0 = disp_q.size();
        bus.fetch_pred_taken = 1'b0; bus.fetch_valid = 1'b1;
        bus.fetch_instr = 32'h0022_1820;
        tick();
        bus.fetch_instr = 32'h1422_0000;
        tick();
        bus.fetch_instr = 32'h0063_3020;
        repeat (3) tick();
        bus.fetch_valid = 1'b0;
        repeat (2) tick();
        tests++; if (disp_q.size() - n0 != 2) begin fails++; $display("FAIL mp_pre: got %0d want 2", disp_q.size() - n0); end
        bus.branch_resolved = 1'b1; bus.branch_taken = 1'b1;
        tick();
        bus.branch_resolved = 1'b0;
        bus.fetch_instr = 32'h2015_0000; bus.fetch_valid = 1'b1;
        tests++; if (bus.recovery_trigger !== 1'b1) begin fails++; $display("FAIL mp_trigger: got %b want 1", bus.recovery_trigger); end
        tests++; if (bus.fetch_ready !== 1'b0 || bus.instr_valid !== 1'b0) begin
            fails++; $display("FAIL mp_block: got rdy=%b v=%b want 0,0", bus.fetch_ready, bus.instr_valid); end
        tick();
        bus.fetch_valid = 1'b0;
        tests++; if (bus.recovery_trigger !== 1'b0 || recov_cnt != 1) begin
            fails++; $display("FAIL mp_onecycle: got trig=%b cnt=%0d want 0,1", bus.recovery_trigger, recov_cnt); end
        tests++; if (bus.mispredict_count !== 16'd1) begin fails++; $display("FAIL mp_count: got %0d want 1", bus.mispredict_count); end
        n0 = disp_q.size();
        repeat (3) tick();
        tests++; if (disp_q.size() != n0) begin fails++; $display("FAIL mp_qflush: got %0d want 0", disp_q.size() - n0); end
        bus.fetch_instr = 32'h0063_3020; bus.fetch_valid = 1'b1;
        tick();
        bus.fetch_valid = 1'b0;
        tick();
        tests++; if (bus.instr_valid !== 1'b1 || bus.dest_index !== 6'd6) begin
            fails++; $display("FAIL mp_sbclear: got v=%b dest=%0d want 1,6", bus.instr_valid, bus.dest_index); end
    endtask

    task automatic test_async_reset();
        int n0;
        int r0;
        logic [31:0] seq [8];
        seq = '{32'h0022_1820, 32'h1022_0000, 32'h1022_0000, 32'h0063_3020,
                32'h0063_3020, 32'h0063_3020, 32'h0063_3020, 32'h0063_3020};
        bus.fetch_pred_taken = 1'b0; bus.fetch_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.fetch_instr = seq[i];
            tick();
        end
        bus.fetch_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        tests++; if (bus.instr_in !== 32'd0 || bus.is_branch !== 1'b0 || bus.src1_index !== 6'd0) begin
            fails++; $display("FAIL ar_fields: got %h br=%b s1=%0d want 0,0,0", bus.instr_in, bus.is_branch, bus.src1_index); end
        tests++; if (bus.mispredict_count !== 16'd0 || bus.fetch_ready !== 1'b0) begin
            fails++; $display("FAIL ar_cnt_rdy: got cnt=%0d rdy=%b want 0,0", bus.mispredict_count, bus.fetch_ready); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        n0 = disp_q.size();
        r0 = recov_cnt;
        bus.branch_resolved = 1'b1; bus.branch_taken = 1'b1;
        repeat (3) tick();
        bus.branch_resolved = 1'b0;
        repeat (3) tick();
        tests++; if (disp_q.size() != n0) begin fails++; $display("FAIL ar_nodisp: got %0d want 0", disp_q.size() - n0); end
        tests++; if (recov_cnt != r0 || bus.mispredict_count !== 16'd0) begin
            fails++; $display("FAIL ar_emptytrk: got recov=%0d cnt=%0d want 0,0", recov_cnt - r0, bus.mispredict_count); end
        bus.fetch_instr = 32'h0063_3020; bus.fetch_valid = 1'b1;
        tick();
        bus.fetch_valid = 1'b0;
        tick();
        tests++; if (bus.instr_valid !== 1'b1 || bus.dest_index !== 6'd6) begin
            fails++; $display("FAIL ar_restart: got v=%b dest=%0d want 1,6", bus.instr_valid, bus.dest_index); end
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw_stall();
        test_load();
        test_full();
        test_branch_ok();
        test_mispredict();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
